shift_ex_stage: RTL and testbench
=================================

# shift_ex_stage

Execute-stage front end for the team's combinational `Shifter`, feeding it and consuming its result. Decodes MIPS R-type shift instructions (SLL, SRL, SRA, SLLV, SRLV, SRAV, ROTR, ROTRV) into the Shifter's `Shift_op`/`Shift_amount`, registers operands in stage S1, and captures the Shifter result in stage S2. Both stages use valid/ready handshakes with backpressure and flush, giving 2-cycle latency at full throughput toward EX/MEM.

## Interface
- No parameters; the data width is fixed at 32.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous kill of both stages (branch mispredict or exception).
- `in_valid` in 1: an instruction is presented.
- `in_ready` out 1: the stage accepts it this cycle.
- `in_funct` in 6: R-type funct field.
- `in_shamt` in 5: shamt field.
- `in_rot` in 1: rotate select (rs bit 0 for SRL; shamt-field bit 0 for SRLV).
- `in_rs_val` in 32: rs operand, the variable shift amount source.
- `in_rt_val` in 32: rt operand, the value to shift.
- `in_rd` in 5: destination register.
- `sh_in` out 32: to `Shift_in`.
- `sh_amount` out 5: to `Shift_amount`.
- `sh_op` out 2: to `Shift_op`.
- `sh_out` in 32: from `Shift_out`.
- `out_valid` out 1: result available.
- `out_ready` in 1: the downstream stage accepts the result.
- `out_result` out 32: shifted value.
- `out_rd` out 5: destination register.
- `out_illegal` out 1: the funct was not a shift; `out_result`=0.

## Operation
- Decode, combinational on inputs, latched into S1 on accept:
  - funct 000000 SLL: op 00, amount shamt.
  - 000010 SRL/ROTR: op 01, or 11 if `in_rot`; amount shamt.
  - 000011 SRA: op 10, amount shamt.
  - 000100 SLLV: op 00, amount rs[4:0].
  - 000110 SRLV/ROTRV: op 01, or 11 if `in_rot`; amount rs[4:0].
  - 000111 SRAV: op 10, amount rs[4:0].
  - Any other funct: illegal; op 00, amount 0, illegal bit set.
- Variable amounts use only rs[4:0]; rs[31:5] is ignored.
- Shifter op encoding: 00 logical left, 01 logical right, 10 arithmetic right, 11 rotate right.
- S1 registers: `s1_valid`, rt value, op, amount, rd, illegal. They drive `sh_in`, `sh_op`, `sh_amount` directly.
- S2 registers: `s2_valid`, result, rd, illegal.
  - S2 captures `sh_out`, or 0 when illegal.
  - S2 drives all `out_*` outputs.
- Handshake rules:
  - `s2_adv` = `s1_valid` & (!`s2_valid` | `out_ready`).
  - `in_ready` = !`s1_valid` | `s2_adv`. It is combinational, does not depend on `in_valid`, and stays low while `flush`=1.
- Once `out_valid` is asserted, `out_result`, `out_rd` and `out_illegal` hold stable until `out_ready` is sampled high.
- `flush` has priority over every update. On the next edge `s1_valid`=`s2_valid`=0. Any input presented in the same cycle is dropped, because `in_ready` is held low while `flush`=1.
- Data registers need no reset; only valid bits do.

## Timing
- Reset (async, `rst_n`=0):
  - `s1_valid`=`s2_valid`=0, so `out_valid`=0 and `in_ready`=1.
  - `sh_in`, `sh_amount`, `sh_op`, `out_result`, `out_rd` and `out_illegal` all reset to 0.
  - Reset asserted mid-operation discards all in-flight instructions immediately; there is no partial output.
- Latency: accept at edge E; `out_valid`=1 in the cycle after edge E+1, i.e. 2 cycles.
- Throughput: 1 instruction per cycle while `out_ready`=1.
- Backpressure with `out_ready`=0 and both stages full: `in_ready`=0 and all state is held.
  - When `out_ready` rises, S2 drains, S1 moves to S2 and a new input is accepted at the same edge.
  - No bubble is inserted and no data is lost.
- Simultaneous S2 drain and S1 refill on one edge is legal and required.
- Shifter path: `sh_*` to `sh_out` is the combinational critical path between S1 and S2. Nothing else sits in it.
- Amount 0 passes rt through unchanged for every op, including SRA and ROTR.

## Test plan
- Reset, then SLL with rt=0x0000_0001 and shamt=31 accepted at edge E.
  - Required: `out_valid` at E+2 with `out_result`=0x8000_0000 and the correct `out_rd`; `out_illegal`=0.
- Back-to-back stream with `out_ready`=1:
  - SRA rt=0x8000_0000, shamt 4 → 0xF800_0000.
  - SRLV rt=0x8000_0000, rs=0xFFFF_FFE4 → 0x0800_0000 (only rs[4:0]=4 used).
  - ROTR rt=0x0000_00F1, shamt 4 → 0x1000_000F.
  - Required: one result per cycle, in order.
- Stream of 6 instructions with `out_ready` held 0 for 3 cycles mid-stream.
  - Required: `in_ready`=0 once both stages are full; outputs stay stable; all 6 results arrive in order with no duplicates or drops.
- Funct 100000 (ADD) presented.
  - Required: `out_illegal`=1, `out_result`=0, and `sh_op`=00 with `sh_amount`=0 during S1.
- `flush` asserted while S1 and S2 are both valid and `in_valid`=1.
  - Required: next cycle `out_valid`=0; the flushed instructions never appear and the concurrent input is not accepted.
- Drop `rst_n` asynchronously mid-stream, between clock edges.
  - Required: `out_valid` and all `sh_*` outputs go to 0 immediately, and `in_ready`=1 until reset is released.

Source files
------------

// File: rtl/shift_ex_stage.sv
// shift_ex_stage: decodes MIPS R-type shifts for the external Shifter, registering operands in S1 and its result in S2.
module shift_ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_funct,
  input  logic [4:0]  in_shamt,
  input  logic        in_rot,
  input  logic [31:0] in_rs_val,
  input  logic [31:0] in_rt_val,
  input  logic [4:0]  in_rd,
  output logic [31:0] sh_in,
  output logic [4:0]  sh_amount,
  output logic [1:0]  sh_op,
  input  logic [31:0] sh_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_rd,
  output logic        out_illegal
);
  logic        legal, s2_adv, rs_unused;
  logic [1:0]  dec_op;
  logic [4:0]  dec_amt;
  logic        s1_valid, s1_ill, s2_valid, s2_ill;
  logic [31:0] s1_rt, s2_res;
  logic [1:0]  s1_op;
  logic [4:0]  s1_amt, s1_rd, s2_rd;
  assign rs_unused = ^in_rs_val[31:5];
  // Legal shifts are 000xyz with yz != 01; bit 2 selects the variable (rs) amount.
  always_comb begin
    legal   = in_funct[5:3] == 3'b000 && in_funct[1:0] != 2'b01;
    dec_op  = !legal || !in_funct[1] ? 2'b00 : in_funct[0] ? 2'b10 : in_rot ? 2'b11 : 2'b01;
    dec_amt = !legal ? 5'd0 : in_funct[2] ? in_rs_val[4:0] : in_shamt;
  end
  assign s2_adv   = s1_valid && (!s2_valid || out_ready);
  assign in_ready = !flush && (!s1_valid || s2_adv);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_rt    <= '0;
      s1_op    <= '0;
      s1_amt   <= '0;
      s1_rd    <= '0;
      s1_ill   <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_rt  <= in_rt_val;
        s1_op  <= dec_op;
        s1_amt <= dec_amt;
        s1_rd  <= in_rd;
        s1_ill <= !legal;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_res   <= '0;
      s2_rd    <= '0;
      s2_ill   <= 1'b0;
    end else if (flush) begin
      s2_valid <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= 1'b1;
      s2_res   <= s1_ill ? 32'd0 : sh_out;
      s2_rd    <= s1_rd;
      s2_ill   <= s1_ill;
    end else if (out_ready) begin
      s2_valid <= 1'b0;
    end
  end
  assign sh_in       = s1_rt;
  assign sh_op       = s1_op;
  assign sh_amount   = s1_amt;
  assign out_valid   = s2_valid;
  assign out_result  = s2_res;
  assign out_rd      = s2_rd;
  assign out_illegal = s2_ill;
endmodule

// File: tb/tb_shift_ex_stage.sv
// tb_shift_ex_stage: directed stimulus with an in-flight queue model checked every cycle.
module tb_shift_ex_stage;
  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, in_rot = 1'b0, out_ready = 1'b1;
  logic [5:0]  in_funct = '0;
  logic [4:0]  in_shamt = '0, in_rd = '0;
  logic [31:0] in_rs_val = '0, in_rt_val = '0;
  logic        in_ready, out_valid, out_illegal;
  logic [31:0] sh_in, sh_out, out_result;
  logic [4:0]  sh_amount, out_rd;
  logic [1:0]  sh_op;

  shift_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_funct(in_funct), .in_shamt(in_shamt), .in_rot(in_rot), .in_rs_val(in_rs_val),
    .in_rt_val(in_rt_val), .in_rd(in_rd), .sh_in(sh_in), .sh_amount(sh_amount), .sh_op(sh_op),
    .sh_out(sh_out), .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] shf(input logic [31:0] v, input logic [1:0] op, input logic [4:0] a);
    logic [63:0] r;
    r = {v, v} >> a;
    case (op)
      2'd0: return v << a;
      2'd1: return v >> a;
      2'd2: return $signed(v) >>> a;
      default: return r[31:0];
    endcase
  endfunction

  // Stand-in for the team's combinational Shifter.
  assign sh_out = shf(sh_in, sh_op, sh_amount);

  typedef struct {
    logic [31:0] rt, res;
    logic [1:0]  op;
    logic [4:0]  amt, rd;
    logic        ill;
    int          acc;
  } ent_t;

  function automatic ent_t model(input logic [5:0] f, input logic [4:0] sa, input logic r,
                                 input logic [31:0] rs, input logic [31:0] rt, input logic [4:0] rd);
    ent_t e;
    e.rt = rt; e.rd = rd; e.ill = 1'b0; e.op = 2'd0; e.amt = 5'd0; e.acc = 0;
    case (f)
      6'h00: e.amt = sa;
      6'h02: begin e.op = r ? 2'd3 : 2'd1; e.amt = sa; end
      6'h03: begin e.op = 2'd2; e.amt = sa; end
      6'h04: e.amt = rs[4:0];
      6'h06: begin e.op = r ? 2'd3 : 2'd1; e.amt = rs[4:0]; end
      6'h07: begin e.op = 2'd2; e.amt = rs[4:0]; end
      default: e.ill = 1'b1;
    endcase
    e.res = e.ill ? 32'd0 : shf(rt, e.op, e.amt);
    return e;
  endfunction

  int checks = 0, failures = 0, cyc = 0, saw_stall = 0;
  ent_t q[$];
  ent_t s1e, ne;
  logic s1v, exp_ov, acc_now = 1'b0, out_now = 1'b0, fl_now = 1'b0;
  logic [31:0] cap_res;
  logic [31:0] log_res[$];
  int log_cyc[$];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    acc_now = in_valid & in_ready;
    out_now = out_valid & out_ready;
    fl_now  = flush;
    cap_res = out_result;
    if (!rst_n) begin
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_sh_in", sh_in, 32'd0);
    end else begin
      exp_ov = q.size() > 0 && cyc > q[0].acc;
      chk("out_valid", 32'(out_valid), 32'(exp_ov));
      if (exp_ov) begin
        chk("out_result", out_result, q[0].res);
        chk("out_rd", 32'(out_rd), 32'(q[0].rd));
        chk("out_illegal", 32'(out_illegal), 32'(q[0].ill));
      end
      chk("in_ready", 32'(in_ready), 32'(!flush && (q.size() < 2 || out_ready)));
      s1v = 1'b0;
      if (q.size() == 2) begin s1e = q[1]; s1v = 1'b1; end
      else if (q.size() == 1 && q[0].acc == cyc) begin s1e = q[0]; s1v = 1'b1; end
      if (s1v) begin
        chk("sh_in", sh_in, s1e.rt);
        chk("sh_op", 32'(sh_op), 32'(s1e.op));
        chk("sh_amount", 32'(sh_amount), 32'(s1e.amt));
      end
      if (in_valid && !in_ready && !flush) saw_stall++;
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      cyc++;
      if (fl_now) q.delete();
      else begin
        if (out_now && q.size() > 0) begin
          log_res.push_back(cap_res);
          log_cyc.push_back(cyc);
          void'(q.pop_front());
        end
        if (acc_now) begin
          ne = model(in_funct, in_shamt, in_rot, in_rs_val, in_rt_val, in_rd);
          ne.acc = cyc;
          q.push_back(ne);
        end
      end
    end
  end

  always @(negedge rst_n) q.delete();

  task automatic present(input logic [5:0] f, input logic [4:0] sa, input logic r,
                         input logic [31:0] rs, input logic [31:0] rt, input logic [4:0] rd);
    in_valid = 1'b1; in_funct = f; in_shamt = sa; in_rot = r; in_rs_val = rs; in_rt_val = rt; in_rd = rd;
  endtask

  task automatic send(input logic [5:0] f, input logic [4:0] sa, input logic r,
                      input logic [31:0] rs, input logic [31:0] rt, input logic [4:0] rd);
    logic done;
    done = 1'b0;
    present(f, sa, r, rs, rt, rd);
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("send_accepted", 32'(done), 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int n0;

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_sh_op", 32'(sh_op), 32'd0);
    chk("reset_sh_amount", 32'(sh_amount), 32'd0);
    chk("reset_out_result", out_result, 32'd0);
    chk("reset_out_rd", 32'(out_rd), 32'd0);
    chk("reset_out_illegal", 32'(out_illegal), 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    idle(1);

    send(6'h00, 5'd31, 1'b0, 32'd0, 32'h0000_0001, 5'd9);
    @(negedge clk);
    chk("sll_not_yet_valid", 32'(out_valid), 32'd0);
    chk("sll_sh_amount", 32'(sh_amount), 32'd31);
    @(negedge clk);
    chk("sll_valid", 32'(out_valid), 32'd1);
    chk("sll_result", out_result, 32'h8000_0000);
    chk("sll_rd", 32'(out_rd), 32'd9);
    chk("sll_illegal", 32'(out_illegal), 32'd0);
    idle(2);

    n0 = log_res.size();
    send(6'h03, 5'd4, 1'b0, 32'd0, 32'h8000_0000, 5'd1);
    send(6'h06, 5'd0, 1'b0, 32'hFFFF_FFE4, 32'h8000_0000, 5'd2);
    send(6'h02, 5'd4, 1'b1, 32'd0, 32'h0000_00F1, 5'd3);
    idle(4);
    chk("stream_count", 32'(log_res.size()), 32'(n0 + 3));
    if (log_res.size() == n0 + 3) begin
      chk("stream_sra", log_res[n0], 32'hF800_0000);
      chk("stream_srlv", log_res[n0 + 1], 32'h0800_0000);
      chk("stream_rotr", log_res[n0 + 2], 32'h1000_000F);
      chk("stream_gap1", 32'(log_cyc[n0 + 1] - log_cyc[n0]), 32'd1);
      chk("stream_gap2", 32'(log_cyc[n0 + 2] - log_cyc[n0 + 1]), 32'd1);
    end

    n0 = log_res.size();
    saw_stall = 0;
    fork
      begin
        send(6'h04, 5'd0, 1'b0, 32'hFFFF_FFE3, 32'h0000_0001, 5'd10);
        send(6'h07, 5'd0, 1'b0, 32'h0000_0021, 32'h8000_0010, 5'd11);
        send(6'h06, 5'd0, 1'b1, 32'h0000_0008, 32'h1234_5678, 5'd12);
        send(6'h02, 5'd16, 1'b0, 32'd0, 32'hABCD_0000, 5'd13);
        send(6'h00, 5'd0, 1'b0, 32'd0, 32'hCAFE_F00D, 5'd14);
        send(6'h03, 5'd0, 1'b0, 32'd0, 32'h8000_0001, 5'd15);
      end
      begin
        idle(2);
        out_ready = 1'b0;
        idle(3);
        out_ready = 1'b1;
      end
    join
    idle(5);
    chk("bp_count", 32'(log_res.size()), 32'(n0 + 6));
    chk("bp_stall_seen", 32'(saw_stall > 0), 32'd1);
    if (log_res.size() == n0 + 6) begin
      chk("bp_sllv", log_res[n0], 32'h0000_0008);
      chk("bp_srav", log_res[n0 + 1], 32'hC000_0008);
      chk("bp_rotrv", log_res[n0 + 2], 32'h7812_3456);
      chk("bp_srl", log_res[n0 + 3], 32'h0000_ABCD);
      chk("bp_sra0", log_res[n0 + 5], 32'h8000_0001);
    end

    send(6'h20, 5'd5, 1'b0, 32'h0000_0007, 32'h0000_DEAD, 5'd4);
    @(negedge clk);
    chk("add_sh_op", 32'(sh_op), 32'd0);
    chk("add_sh_amount", 32'(sh_amount), 32'd0);
    @(negedge clk);
    chk("add_illegal", 32'(out_illegal), 32'd1);
    chk("add_result", out_result, 32'd0);
    idle(3);

    out_ready = 1'b0;
    send(6'h00, 5'd1, 1'b0, 32'd0, 32'h0000_0011, 5'd20);
    send(6'h00, 5'd2, 1'b0, 32'd0, 32'h0000_0022, 5'd21);
    present(6'h00, 5'd3, 1'b0, 32'd0, 32'h0000_0033, 5'd22);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_full_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    n0 = log_res.size();
    @(negedge clk);
    chk("flush_full_out_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    idle(4);
    chk("flush_full_nothing", 32'(log_res.size()), 32'(n0));

    send(6'h00, 5'd4, 1'b0, 32'd0, 32'h0000_0044, 5'd23);
    present(6'h00, 5'd5, 1'b0, 32'd0, 32'h0000_0055, 5'd24);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_s1_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    idle(4);
    chk("flush_s1_nothing", 32'(log_res.size()), 32'(n0));

    out_ready = 1'b0;
    send(6'h00, 5'd6, 1'b0, 32'd0, 32'h0000_0066, 5'd25);
    send(6'h02, 5'd3, 1'b1, 32'd0, 32'h0000_00FF, 5'd26);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_sh_in", sh_in, 32'd0);
    chk("arst_sh_op", 32'(sh_op), 32'd0);
    chk("arst_sh_amount", 32'(sh_amount), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    idle(3);
    chk("arst_nothing", 32'(log_res.size()), 32'(n0));
    send(6'h02, 5'd8, 1'b0, 32'd0, 32'h0000_0100, 5'd27);
    idle(3);
    chk("post_rst_count", 32'(log_res.size()), 32'(n0 + 1));
    if (log_res.size() == n0 + 1) chk("post_rst_srl", log_res[n0], 32'h0000_0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
